serial_deser: RTL and testbench
===============================

# serial_deser

Serial-to-parallel deserializer that consumes the registered one-bit stream produced by the single-bit D flip-flop stage and assembles it into WIDTH-bit words. It accepts one bit per cycle when enabled and frames words with an explicit sync strobe. Completed words are presented on a one-deep output register with a valid/ready handshake. Words that arrive while the output register is still full are dropped and flagged as an overflow.

## Interface
Parameters:
- WIDTH, 8: word width in bits; legal range 2–32.
- MSB_FIRST, 1: 1 means the first received bit lands in o_data[WIDTH-1]; 0 means it lands in o_data[0].

Ports:
- i_clk, in, 1: sole clock; all state updates on the rising edge.
- i_rst, in, 1: reset, asynchronous and active-high; clears all state immediately.
- i_d, in, 1: serial data bit, sampled only when i_en=1.
- i_en, in, 1: bit-valid strobe.
- i_sync, in, 1: start-of-frame; discards any partial word.
- i_ready, in, 1: downstream accepts o_data.
- i_ovf_clr, in, 1: clears o_ovf.
- o_data, out, WIDTH: assembled word.
- o_valid, out, 1: o_data holds an unconsumed word.
- o_ovf, out, 1: sticky overflow flag.
- o_par_err, out, 1: parity error for the word in o_data; present only with SERIAL_DESER_PARITY_EN.

## Operation
- Reset values: o_data=0, o_valid=0, o_ovf=0, o_par_err=0; bit counter=0; state=IDLE.
- FSM states and transitions:
  - IDLE: on i_en, go to SHIFT.
  - SHIFT: on the WIDTH-th accepted bit, go to IDLE (or to PARITY when the macro is defined).
  - PARITY: on an accepted bit, go to IDLE.
- Bit counter width is $clog2(WIDTH+1). It increments only on accepted bits and saturates at WIDTH; there is no wrap.
- i_sync=1 with i_en=1: the shift register and counter reset, and the current i_d becomes bit 0 of a new frame. State becomes SHIFT.
- i_sync=1 with i_en=0: the counter clears and the state returns to IDLE.
- Word completion, output register empty, or o_valid&&i_ready in the same cycle: load o_data and hold o_valid at 1.
- Word completion while o_valid=1 and i_ready=0: drop the new word, leave o_data unchanged, set o_ovf.
- Handshake: a transfer occurs on any edge where o_valid&&i_ready. Without a simultaneous completion, o_valid falls after that edge. o_data is stable while o_valid=1 and i_ready=0.
- o_ovf stays set until i_ovf_clr. If an overflow occurs in the same cycle as i_ovf_clr, the set wins.
- Reset asserted mid-frame: the partial word is lost and no o_valid is produced.

## Timing
- Latency: last data bit accepted at edge N, then o_valid=1 and o_data is valid after edge N.
- Throughput: one bit per cycle. Back-to-back words with i_ready=1 are delivered with no gaps and no loss.
- i_en low cycles are allowed anywhere in a frame; shift state holds during gaps.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- SERIAL_DESER_PARITY_EN defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, captured in the PARITY state.
  - o_valid rises only after the parity bit is accepted.
  - o_par_err = XOR of data and parity bits, registered with o_data.
  - The word is delivered even on error.
- SERIAL_DESER_PARITY_EN undefined: no PARITY state, no o_par_err port, and a frame is exactly WIDTH bits.

## Structure
- Package serial_deser_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the WIDTH legality limits;
  - a parity helper function.
- Sub-module serial_deser_shift: WIDTH-bit shift register with the MSB_FIRST direction, clear on sync, and a shift enable.
- Top level owns the FSM, counter, output register and flags.

## Test plan
1. Reset mid-frame: 3 bits shifted, then i_rst=1 → all outputs 0 immediately. Afterwards, 8 bits of 0xA5 produce exactly one word, 0xA5.
2. WIDTH=8, MSB_FIRST=1, i_ready=1: bits 1,0,1,0,0,1,0,1 on consecutive cycles → o_data=8'hA5 and o_valid high for one cycle, starting after the 8th edge. With MSB_FIRST=0, the same bits → 8'hA5 (LSB first).
3. i_ready=0 with 0xA5 held, then 0x3C completed → o_data stays 0xA5 and o_ovf=1. Then i_ovf_clr=1 → o_ovf=0.
4. i_sync after 3 bits (1,1,1), then 8 bits of 0x00 → o_data=0x00 and no earlier word is emitted.
5. 0xA5 bits interleaved with 2-cycle i_en gaps → o_data=0xA5, with o_valid after the edge of the last accepted bit.
6. With SERIAL_DESER_PARITY_EN: 0xA5 plus parity 0 → o_par_err=0; 0xA5 plus parity 1 → o_par_err=1, with o_data=0xA5 in both cases.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial_deser deserializer.
// Parity framing is enabled with the SERIAL_DESER_PARITY_EN macro.
package serial_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Even parity over a word zero-extended to WIDTH_MAX bits.
    function automatic logic even_parity(input logic [WIDTH_MAX-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_deser_shift.sv
// WIDTH-bit serial shift register with selectable direction and frame clear.
// o_word_next is the value the register takes at the next rising edge.
module serial_deser_shift #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_d,
    output logic [WIDTH-1:0] o_word_next
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] base;

    // A clear combined with a shift starts the new frame with the current bit.
    always_comb begin
        base = i_clr ? '0 : sr_q;
        sr_d = base;
        if (i_shift) begin
            if (MSB_FIRST) begin
                sr_d = {base[WIDTH-2:0], i_d};
            end else begin
                sr_d = {i_d, base[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_word_next = sr_d;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with sync framing and a one-deep valid/ready output.
// Define SERIAL_DESER_PARITY_EN to add a trailing even-parity bit and the o_par_err output.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_d,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_ready,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_ovf
`ifdef SERIAL_DESER_PARITY_EN
    ,
    output logic             o_par_err
`endif
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_deser: WIDTH out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             shift_en;
    logic             word_done;
    logic [WIDTH-1:0] word_next;
`ifdef SERIAL_DESER_PARITY_EN
    logic             par_q, par_d;
    logic             word_par;
`endif

    // The shifter is frozen while waiting for the parity bit, so word_next
    // equals the captured data word in that state.
    assign shift_en = i_en && (i_sync || state_q != PARITY);

    serial_deser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (i_sync),
        .i_shift     (shift_en),
        .i_d         (i_d),
        .o_word_next (word_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        word_par  = 1'b0;
`endif
        if (i_sync) begin
            if (i_en) begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (i_en) begin
            case (state_q)
                IDLE, SHIFT: begin
                    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
                    state_d = SHIFT;
                    if (cnt_d == CNT_FULL) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d   = IDLE;
                        cnt_d     = '0;
                        word_done = 1'b1;
`endif
                    end
                end
                PARITY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef SERIAL_DESER_PARITY_EN
                    word_done = 1'b1;
                    word_par  = even_parity(WIDTH_MAX'(word_next)) ^ i_d;
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Overflow set takes priority over a simultaneous clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_DESER_PARITY_EN
        par_d   = par_q;
`endif
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || i_ready) begin
                data_d  = word_next;
                valid_d = 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                par_d   = word_par;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_DESER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_ovf     = ovf_q;
`ifdef SERIAL_DESER_PARITY_EN
    assign o_par_err = par_q;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: one MSB-first and one LSB-first instance
// share stimulus and are checked against a bit-queue reference model.
module tb_serial_deser;

    localparam int W = 8;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        logic [W-1:0] dm;
        logic [W-1:0] dl;
        logic         pe;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         d = 1'b0, en = 1'b0, sync = 1'b0, ready = 1'b0, ovf_clr = 1'b0;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, ovf_m, ovf_l, perr_m, perr_l;

    int   checks = 0;
    int   fails  = 0;
    exp_t sbq[$];
    bit   frame[$];
    bit   m_full, m_ovf;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_en(en), .i_sync(sync),
        .i_ready(ready), .i_ovf_clr(ovf_clr),
        .o_data(data_m), .o_valid(valid_m), .o_ovf(ovf_m)
`ifdef SERIAL_DESER_PARITY_EN
        , .o_par_err(perr_m)
`endif
    );

    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_d(d), .i_en(en), .i_sync(sync),
        .i_ready(ready), .i_ovf_clr(ovf_clr),
        .o_data(data_l), .o_valid(valid_l), .o_ovf(ovf_l)
`ifdef SERIAL_DESER_PARITY_EN
        , .o_par_err(perr_l)
`endif
    );

`ifndef SERIAL_DESER_PARITY_EN
    assign perr_m = 1'b0;
    assign perr_l = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted bits of the current frame, form a word
    // once the frame is complete, and track output occupancy and overflow.
    always @(posedge clk or posedge rst) begin
        bit   done, ovf_set;
        exp_t e;
        if (rst) begin
            frame.delete();
            sbq.delete();
            m_full = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            done    = 1'b0;
            ovf_set = 1'b0;
            e.dm    = '0;
            e.dl    = '0;
            e.pe    = 1'b0;
            if (en) begin
                if (sync) frame.delete();
                frame.push_back(d);
                if (frame.size() == FL) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        e.dm[W-1-i] = frame[i];
                        e.dl[i]     = frame[i];
                    end
`ifdef SERIAL_DESER_PARITY_EN
                    for (int i = 0; i < FL; i++) e.pe ^= frame[i];
`endif
                    frame.delete();
                end
            end else if (sync) begin
                frame.delete();
            end
            if (done) begin
                if (!m_full || ready) begin
                    m_full = 1'b1;
                    sbq.push_back(e);
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (m_full && ready) begin
                m_full = 1'b0;
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    // Monitor: flag/valid checks every cycle; pop and compare on each transfer.
    always @(negedge clk) begin
        exp_t e;
        #1;
        chk("valid_msb", valid_m, m_full);
        chk("valid_lsb", valid_l, m_full);
        chk("ovf_msb", ovf_m, m_ovf);
        chk("ovf_lsb", ovf_l, m_ovf);
        if (valid_m && ready && !rst) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_underflow: got word %0h expected no word at %0t", data_m, $time);
            end else begin
                e = sbq.pop_front();
                chk("data_msb", data_m, e.dm);
                chk("data_lsb", data_l, e.dl);
                chk("par_err_msb", perr_m, e.pe);
                chk("par_err_lsb", perr_l, e.pe);
            end
        end
    end

    task automatic cyc(input bit e, input bit dd, input bit s);
        @(negedge clk);
        en   = e;
        d    = dd;
        sync = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Sends w[W-1] first; appends the even-parity bit (optionally inverted) in parity builds.
    task automatic send_word(input logic [W-1:0] w, input int gap, input bit s0, input bit perr_inj);
        bit p;
        p = perr_inj;
        for (int i = W - 1; i >= 0; i--) begin
            cyc(1'b1, w[i], (i == W - 1) ? s0 : 1'b0);
            p ^= w[i];
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
        end
`ifdef SERIAL_DESER_PARITY_EN
        cyc(1'b1, p, 1'b0);
`endif
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_data", data_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_ovf", ovf_m, 0);
        chk("rst_par", perr_m, 0);

        // Mid-frame reset with a held word and a pending overflow.
        ready = 1'b0;
        send_word(8'h5A, 0, 1'b0, 1'b0);
        send_word(8'h77, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_data", data_m, 0);
        chk("midrst_valid", valid_m, 0);
        chk("midrst_ovf", ovf_m, 0);
        chk("midrst_par", perr_m, 0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        send_word(8'hA5, 0, 1'b0, 1'b0);
        idle(3);

        // Back-to-back words.
        send_word(8'hA5, 0, 1'b0, 1'b0);
        send_word(8'h3C, 0, 1'b0, 1'b0);
        idle(2);

        // Overflow while held, clear, then set-wins-over-clear.
        ready = 1'b0;
        send_word(8'hA5, 0, 1'b0, 1'b0);
        send_word(8'h3C, 0, 1'b0, 1'b0);
        idle(2);
        chk("ovf_set", ovf_m, 1);
        chk("ovf_hold_data", data_m, 8'hA5);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        idle(1);
        chk("ovf_cleared", ovf_m, 0);
        ovf_clr = 1'b1;
        send_word(8'hC3, 0, 1'b0, 1'b0);
        idle(1);
        ovf_clr = 1'b0;
        idle(1);
        chk("ovf_set_wins", ovf_m, 1);
        ready = 1'b1;
        idle(2);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;

        // Sync with a bit after a partial frame; then sync without a bit.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        send_word(8'h00, 0, 1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        send_word(8'h96, 0, 1'b0, 1'b0);
        idle(2);

        // Gaps inside a frame, then parity good/bad.
        send_word(8'hA5, 2, 1'b0, 1'b0);
        idle(2);
        send_word(8'hA5, 0, 1'b0, 1'b0);
        send_word(8'hA5, 0, 1'b0, 1'b1);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 3) != 0);
            d       = 1'($urandom);
            sync    = ($urandom_range(0, 24) == 0);
            ready   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 20; i++) send_word(W'($urandom), $urandom_range(0, 1), 1'b0, 1'($urandom_range(0, 1)));

        @(negedge clk);
        ready   = 1'b1;
        ovf_clr = 1'b0;
        idle(6);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
